// File: rtl/seq_det_pkg.sv
// Shared constants and the elaboration-time KMP next-state table builder
// used by the parametrised serial-pattern detector.
package seq_det_pkg;

  localparam int PAT_LEN_MAX = 16;
  localparam int PAT_LEN_MIN = 2;
  localparam int TAB_ST_W    = 5;

  typedef logic [TAB_ST_W-1:0] tab_state_t;
  typedef logic [PAT_LEN_MAX:0][1:0][TAB_ST_W-1:0] next_tab_t;

  // Bit at position pos of the pattern, counted from the first bit received.
  function automatic logic pat_bit(logic [PAT_LEN_MAX-1:0] pattern, int pat_len, int pos);
    logic [3:0] idx;
    idx = 4'(pat_len - 1 - pos);
    return pattern[idx];
  endfunction

  function automatic next_tab_t build_next_table(int pat_len,
                                                 logic [PAT_LEN_MAX-1:0] pattern,
                                                 bit overlap);
    next_tab_t  tab;
    int         base;
    int         seq_len;
    int         best;
    int         m;
    bit         hit;
    logic       sbit;
    logic [4:0] ki;
    logic       bi;
    tab = '0;
    for (int k = 0; k <= PAT_LEN_MAX; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (k <= pat_len) begin
          // The full-match state restarts from scratch when overlap is off.
          base    = (k == pat_len && !overlap) ? 0 : k;
          seq_len = base + 1;
          best    = 0;
          for (int j = 1; j <= PAT_LEN_MAX; j++) begin
            if (j <= seq_len && j <= pat_len) begin
              hit = 1'b1;
              for (int i = 0; i < PAT_LEN_MAX; i++) begin
                if (i < j) begin
                  m    = seq_len - j + i;
                  sbit = (m < base) ? pat_bit(pattern, pat_len, m) : b[0];
                  if (pat_bit(pattern, pat_len, i) != sbit) hit = 1'b0;
                end
              end
              if (hit) best = j;
            end
          end
          ki = 5'(k);
          bi = b[0];
          tab[ki][bi] = tab_state_t'(best);
        end
      end
    end
    return tab;
  endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state lookup; the table is fixed at elaboration from
// the pattern parameters.
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int                     PAT_LEN  = 5,
  parameter logic [PAT_LEN_MAX-1:0] PAT_BITS = 16'b11011,
  parameter bit                     OVERLAP  = 1'b1
) (
  input  logic [$clog2(PAT_LEN+1)-1:0] state,
  input  logic                         in,
  output logic [$clog2(PAT_LEN+1)-1:0] next_state
);

  localparam int        ST_W     = $clog2(PAT_LEN + 1);
  localparam next_tab_t NEXT_TAB = build_next_table(PAT_LEN, PAT_BITS, OVERLAP);

  logic [TAB_ST_W-1:0] row;

  always_comb begin
    row        = TAB_ST_W'(state);
    next_state = ST_W'(NEXT_TAB[row][in]);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with enable, synchronous clear
// and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 5,
  parameter     PATTERN = 5'b11011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in,
  input  logic                         en,
  input  logic                         clear,
  output logic                         out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(PAT_LEN+1)-1:0] progress
);

  localparam int               ST_W    = $clog2(PAT_LEN + 1);
  localparam logic [ST_W-1:0]  FULL    = ST_W'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN %0d outside %0d..%0d", PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX);
  end
  if ($bits(PATTERN) > PAT_LEN) begin : g_bad_pat
    $error("seq_detector_param: PATTERN is %0d bits, wider than PAT_LEN %0d", $bits(PATTERN), PAT_LEN);
  end

  logic [ST_W-1:0]  state_q, state_d;
  logic [ST_W-1:0]  next_state;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  seq_det_next_state #(
    .PAT_LEN  (PAT_LEN),
    .PAT_BITS (16'(PATTERN)),
    .OVERLAP  (OVERLAP)
  ) u_next_state (
    .state      (state_q),
    .in         (in),
    .next_state (next_state)
  );

  // Every enabled edge that lands in the full state is a new detection,
  // including re-entry from the full state itself.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = '0;
      out_d   = 1'b0;
      cnt_d   = '0;
    end else if (en) begin
      state_d = next_state;
      out_d   = (next_state == FULL);
      if (next_state == FULL && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign progress  = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Four detector configurations share one stimulus stream; a history-based
// reference model checks all of them every cycle, plus hand-computed points.
module tb_seq_detector_param;

  logic clk;
  logic rst;
  logic in_bit;
  logic en;
  logic clear;

  logic       out_ov, out_nov, out_sat, out_p2;
  logic [7:0] cnt_ov, cnt_nov, cnt_p2;
  logic [1:0] cnt_sat;
  logic [2:0] prog_ov, prog_nov, prog_sat;
  logic [1:0] prog_p2;

  int n_vec  = 0;
  int n_miss = 0;

  localparam int          M_LEN  [4] = '{5, 5, 5, 2};
  localparam logic [15:0] M_PAT  [4] = '{16'h1B, 16'h1B, 16'h1B, 16'h3};
  localparam bit          M_OVL  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int          M_CNTW [4] = '{8, 8, 2, 8};

  localparam int T1_PROG_OV  [8] = '{1, 2, 3, 4, 5, 3, 4, 5};
  localparam int T1_OUT_OV   [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  localparam int T1_PROG_NOV [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  localparam int T1_OUT_NOV  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  localparam int T3_PROG     [7] = '{1, 2, 2, 2, 3, 4, 5};

  typedef struct {
    logic [31:0] hist;
    int          hlen;
    int          st;
    int          cnt;
  } model_t;

  model_t mdl [4];

  seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .in(in_bit), .en(en), .clear(clear),
    .out(out_ov), .match_cnt(cnt_ov), .progress(prog_ov));

  seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .in(in_bit), .en(en), .clear(clear),
    .out(out_nov), .match_cnt(cnt_nov), .progress(prog_nov));

  seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in(in_bit), .en(en), .clear(clear),
    .out(out_sat), .match_cnt(cnt_sat), .progress(prog_sat));

  seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) u_p2 (
    .clk(clk), .rst(rst), .in(in_bit), .en(en), .clear(clear),
    .out(out_p2), .match_cnt(cnt_p2), .progress(prog_p2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Longest tail of the accepted bits that equals a prefix of the pattern.
  function automatic int match_len(logic [31:0] hist, int hlen, int idx);
    bit ok;
    for (int j = M_LEN[idx]; j >= 1; j--) begin
      if (j <= hlen) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (1'(M_PAT[idx] >> (M_LEN[idx] - 1 - i)) != 1'(hist >> (j - 1 - i))) ok = 1'b0;
        if (ok) return j;
      end
    end
    return 0;
  endfunction

  function automatic model_t step(model_t m, int idx, logic b);
    model_t n;
    n = m;
    if (!M_OVL[idx] && m.st == M_LEN[idx]) begin
      n.hist = '0;
      n.hlen = 0;
    end
    n.hist = {n.hist[30:0], b};
    if (n.hlen < 32) n.hlen = n.hlen + 1;
    n.st = match_len(n.hist, n.hlen, idx);
    if (n.st == M_LEN[idx] && n.cnt < (1 << M_CNTW[idx]) - 1) n.cnt = n.cnt + 1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || clear) mdl[i] <= '{32'd0, 0, 0, 0};
      else if (en)      mdl[i] <= step(mdl[i], i, in_bit);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_miss = n_miss + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("ov.out",    int'(out_ov),   int'(mdl[0].st == M_LEN[0]));
    checkOutput("ov.cnt",    int'(cnt_ov),   mdl[0].cnt);
    checkOutput("ov.prog",   int'(prog_ov),  mdl[0].st);
    checkOutput("nov.out",   int'(out_nov),  int'(mdl[1].st == M_LEN[1]));
    checkOutput("nov.cnt",   int'(cnt_nov),  mdl[1].cnt);
    checkOutput("nov.prog",  int'(prog_nov), mdl[1].st);
    checkOutput("sat.out",   int'(out_sat),  int'(mdl[2].st == M_LEN[2]));
    checkOutput("sat.cnt",   int'(cnt_sat),  mdl[2].cnt);
    checkOutput("sat.prog",  int'(prog_sat), mdl[2].st);
    checkOutput("p2.out",    int'(out_p2),   int'(mdl[3].st == M_LEN[3]));
    checkOutput("p2.cnt",    int'(cnt_p2),   mdl[3].cnt);
    checkOutput("p2.prog",   int'(prog_p2),  mdl[3].st);
  end

  task automatic applyStimulus(input logic b, input logic e, input logic c);
    in_bit = b;
    en     = e;
    clear  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [16:0] sat_stream;
    rst    = 1'b1;
    in_bit = 1'b0;
    en     = 1'b0;
    clear  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset.out",  int'(out_ov),  0);
    checkOutput("reset.cnt",  int'(cnt_ov),  0);
    checkOutput("reset.prog", int'(prog_ov), 0);

    // Overlapping versus non-overlapping on 1,1,0,1,1,0,1,1.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'(8'b11011011 >> (7 - i)), 1'b1, 1'b0);
      checkOutput($sformatf("t1.ov.prog[%0d]", i),  int'(prog_ov),  T1_PROG_OV[i]);
      checkOutput($sformatf("t1.ov.out[%0d]", i),   int'(out_ov),   T1_OUT_OV[i]);
      checkOutput($sformatf("t1.nov.prog[%0d]", i), int'(prog_nov), T1_PROG_NOV[i]);
      checkOutput($sformatf("t1.nov.out[%0d]", i),  int'(out_nov),  T1_OUT_NOV[i]);
    end
    checkOutput("t1.ov.cnt",  int'(cnt_ov),  2);
    checkOutput("t1.nov.cnt", int'(cnt_nov), 1);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr.cnt",  int'(cnt_ov),  0);
    checkOutput("clr.prog", int'(prog_ov), 0);

    // Run of ones falls back onto the two-bit prefix.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'(7'b1111011 >> (6 - i)), 1'b1, 1'b0);
      checkOutput($sformatf("t3.prog[%0d]", i), int'(prog_ov), T3_PROG[i]);
      checkOutput($sformatf("t3.out[%0d]", i),  int'(out_ov),  int'(i == 6));
    end
    checkOutput("t3.cnt", int'(cnt_ov), 1);

    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("t4.hold.prog[%0d]", i), int'(prog_ov), 2);
      checkOutput($sformatf("t4.hold.out[%0d]", i),  int'(out_ov),  0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4.prog4", int'(prog_ov), 4);
    checkOutput("t4.out4",  int'(out_ov),  0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4.out",   int'(out_ov), 1);
    checkOutput("t4.cnt",   int'(cnt_ov), 1);

    // Five overlapping matches into a two-bit counter.
    applyStimulus(1'b0, 1'b0, 1'b1);
    sat_stream = 17'b11011011011011011;
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(sat_stream[16 - i], 1'b1, 1'b0);
      if (out_sat) pulses = pulses + 1;
      if (i == 4)  checkOutput("t5.cnt1", int'(cnt_sat), 1);
      if (i == 7)  checkOutput("t5.cnt2", int'(cnt_sat), 2);
      if (i == 10) checkOutput("t5.cnt3", int'(cnt_sat), 3);
      if (i == 16) checkOutput("t5.cnt5", int'(cnt_sat), 3);
    end
    checkOutput("t5.pulses", pulses, 5);
    checkOutput("t5.ov.cnt", int'(cnt_ov), 5);

    // Clear wins over the completing bit.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t7.prog4", int'(prog_ov), 4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t7.out",  int'(out_ov),  0);
    checkOutput("t7.cnt",  int'(cnt_ov),  0);
    checkOutput("t7.prog", int'(prog_ov), 0);

    // Asynchronous reset discards a partial match.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t6.prog4", int'(prog_ov), 4);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6.async.prog", int'(prog_ov), 0);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t6.out",  int'(out_ov),  0);
    checkOutput("t6.prog", int'(prog_ov), 1);

    // Two-bit pattern on a run of ones keeps out high.
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("t8.prog[%0d]", i), int'(prog_p2), (i == 0) ? 1 : 2);
      checkOutput($sformatf("t8.out[%0d]", i),  int'(out_p2),  (i == 0) ? 0 : 1);
      checkOutput($sformatf("t8.cnt[%0d]", i),  int'(cnt_p2),  i);
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
